// File: rtl/flg_match_sched.sv
// Flag-match scheduler: ANDs an activation/weight flag pair and walks every match LSB-first, emitting compressed-buffer addresses.
// Optional FLGSEQ_PERF_CNT_EN adds saturating handshake/stall counters.
module flg_match_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    localparam int POS_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flg_valid,
    output logic                  flg_ready,
    input  logic [DATA_WIDTH-1:0] flg_act,
    input  logic [DATA_WIDTH-1:0] flg_wei,
    input  logic                  flg_clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_act_addr,
    output logic [ADDR_WIDTH-1:0] out_wei_addr,
    output logic [POS_WIDTH-1:0]  out_pos,
    output logic                  out_last,
    output logic                  word_done,
    output logic [1:0]            dbg_state,
`ifdef FLGSEQ_PERF_CNT_EN
    output logic [31:0]           perf_match_cnt,
    output logic [31:0]           perf_stall_cnt,
`endif
    output logic                  busy
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are
    // both high; valid never waits on ready, and a raised valid holds its payload until taken.

    localparam int CNT_WIDTH = POS_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] act_q, act_d;
    logic [DATA_WIDTH-1:0] wei_q, wei_d;
    logic [DATA_WIDTH-1:0] match_q, match_d;
    logic [ADDR_WIDTH-1:0] act_base_q, act_base_d;
    logic [ADDR_WIDTH-1:0] wei_base_q, wei_base_d;

    logic [DATA_WIDTH-1:0] below_mask;
    logic [POS_WIDTH-1:0]  lsb_pos;
    logic                  run;
    logic                  has_match;
    logic                  one_hot;
    logic                  hs;

    function automatic logic [CNT_WIDTH-1:0] popcnt(input logic [DATA_WIDTH-1:0] vec);
        logic [CNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            cnt = cnt + CNT_WIDTH'(vec[i]);
        end
        return cnt;
    endfunction

    always_comb begin
        lsb_pos = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (match_q[i]) begin
                lsb_pos = POS_WIDTH'(i);
            end
        end
    end

    // Bits strictly below the lowest match select the compressed entries already consumed.
    assign below_mask = (match_q & (~match_q + ONE)) - ONE;
    assign run        = (state_q == ST_RUN);
    assign has_match  = (match_q != '0);
    assign one_hot    = has_match && ((match_q & (match_q - ONE)) == '0);
    assign hs         = out_valid && out_ready;

    assign out_valid    = run && has_match;
    assign out_last     = run && one_hot;
    assign out_pos      = lsb_pos;
    assign out_act_addr = act_base_q + ADDR_WIDTH'(popcnt(act_q & below_mask));
    assign out_wei_addr = wei_base_q + ADDR_WIDTH'(popcnt(wei_q & below_mask));
    assign flg_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign word_done    = (state_q == ST_DONE);
    assign dbg_state    = state_q;

    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        wei_d      = wei_q;
        match_d    = match_q;
        act_base_d = act_base_q;
        wei_base_d = wei_base_q;
        case (state_q)
            ST_IDLE: begin
                if (flg_valid) begin
                    act_d   = flg_act;
                    wei_d   = flg_wei;
                    match_d = flg_act & flg_wei;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!has_match) begin
                    state_d = ST_DONE;
                end else if (hs) begin
                    match_d = match_q & (match_q - ONE);
                    if (one_hot) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                act_base_d = act_base_q + ADDR_WIDTH'(popcnt(act_q));
                wei_base_d = wei_base_q + ADDR_WIDTH'(popcnt(wei_q));
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flg_clear) begin
            act_base_d = '0;
            wei_base_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            act_q      <= '0;
            wei_q      <= '0;
            match_q    <= '0;
            act_base_q <= '0;
            wei_base_q <= '0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            wei_q      <= wei_d;
            match_q    <= match_d;
            act_base_q <= act_base_d;
            wei_base_q <= wei_base_d;
        end
    end

`ifdef FLGSEQ_PERF_CNT_EN
    logic [31:0] perf_match_cnt_q, perf_match_cnt_d;
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_match_cnt_d = perf_match_cnt_q;
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (hs && (perf_match_cnt_q != 32'hFFFF_FFFF)) begin
            perf_match_cnt_d = perf_match_cnt_q + 32'd1;
        end
        if (out_valid && !out_ready && (perf_stall_cnt_q != 32'hFFFF_FFFF)) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        end
        if (flg_clear) begin
            perf_match_cnt_d = '0;
            perf_stall_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_match_cnt_q <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_match_cnt_q <= perf_match_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_match_cnt = perf_match_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: doc/flg_match_sched.md
# flg_match_sched

Sequencer for the sparse flag-matching datapath. It accepts one pair of activation/weight flag words per handshake and forms their match vector, the AND of the two words. It then walks every matched bit from LSB to MSB, emitting one compressed-memory address pair per cycle under valid/ready backpressure. It keeps running base addresses across words so the compressed activation and weight buffers are addressed contiguously; it sits between the flag FIFOs and the PE operand fetch.

## Interface
- DATA_WIDTH, 32, flag word width in bits; power of two, at least 4
- ADDR_WIDTH, 10, compressed-buffer address width
- POS_WIDTH, $clog2(DATA_WIDTH), bit-position width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flg_valid  in  1  flag pair offered
- flg_ready  out  1  scheduler can accept a flag pair
- flg_act  in  DATA_WIDTH  activation nonzero flags
- flg_wei  in  DATA_WIDTH  weight nonzero flags
- flg_clear  in  1  synchronous pulse: zero both base addresses (start of tile)
- out_valid  out  1  address pair valid
- out_ready  in  1  consumer accepts pair
- out_act_addr  out  ADDR_WIDTH  compressed activation address
- out_wei_addr  out  ADDR_WIDTH  compressed weight address
- out_pos  out  POS_WIDTH  bit position of the current match
- out_last  out  1  current pair is the last match of the word
- word_done  out  1  one-cycle pulse when a word is fully retired
- busy  out  1  state is not IDLE

## Operation
- Registers: act_r, wei_r, match_r (DATA_WIDTH each); act_base, wei_base (ADDR_WIDTH each); 3-state FSM IDLE/RUN/DONE.
- IDLE:
  - flg_ready=1.
  - On flg_valid: load act_r=flg_act, wei_r=flg_wei, match_r=flg_act&flg_wei, then go to RUN.
- RUN:
  - out_valid = (match_r != 0).
  - out_pos = index of the lowest set bit of match_r.
  - out_act_addr = act_base + popcount(act_r & ((1<<out_pos)-1)), modulo 2^ADDR_WIDTH.
  - out_wei_addr is computed the same way from wei_r and wei_base.
  - out_last = exactly one bit set in match_r.
  - On out_valid&&out_ready: clear that bit in match_r.
  - When match_r==0, either at entry or after the last handshake, go to DONE.
- DONE, one cycle:
  - act_base += popcount(act_r); wei_base += popcount(wei_r). Both wrap modulo 2^ADDR_WIDTH.
  - word_done=1, then go to IDLE.
- Zero-match word: RUN emits nothing. Its flags still advance the bases.
- flg_clear: zeroes both bases on the next edge in any state. If it coincides with the DONE update, clear wins. The current word's addresses are unaffected until the next emitted pair.
- out_* are driven only from registers through combinational logic. There is no flg_* to out_* combinational path.
- While out_valid=1 and out_ready=0, all out_* are held stable.
- flg_ready=0 in RUN and DONE.

## Timing
- Reset: FSM=IDLE, all registers 0.
  - flg_ready=1, out_valid=0, out_last=0, word_done=0, busy=0, out_*_addr=0, out_pos=0.
- Accept at edge T: out_valid is first high in cycle T+1.
- Throughput: 1 pair/cycle with out_ready held high.
- A word with N matches occupies N cycles in RUN (N=0 gives 1 cycle), plus 1 DONE cycle and 1 IDLE cycle before the next accept. The minimum per word is N+2 cycles.
- The last handshake at edge E gives DONE in cycle E+1 (word_done=1) and IDLE with flg_ready=1 in E+2.
- Reset asserted mid-word: the word is discarded and the bases are lost. Outputs return to reset values immediately.

## Configuration
- FLGSEQ_PERF_CNT_EN defined: adds the following 32-bit saturating outputs, cleared by reset and by flg_clear.
  - perf_match_cnt: number of out handshakes.
  - perf_stall_cnt: cycles with out_valid&&!out_ready.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset then flg_act=0x0000_00F0, flg_wei=0x0000_0030 -> pairs (pos4, act 0, wei 0) and (pos5, act 1, wei 1, last=1); word_done; act_base=4, wei_base=2.
- Second word flg_act=flg_wei=0x8000_0001 with no clear -> (pos0, act 4, wei 2) then (pos31, act 5, wei 3, last).
- flg_act=0xFFFF_0000, flg_wei=0x0000_FFFF -> no out_valid; word_done at T+2; act_base=16, wei_base=16.
- 3-match word with out_ready toggled 1,0,0,1,1 -> outputs held while stalled; 3 handshakes total; perf_stall_cnt=2 when FLGSEQ_PERF_CNT_EN is defined.
- ADDR_WIDTH=4, act_base=14, flg_act=flg_wei=0x7 -> act addresses 14,15,0; act_base wraps to 1.
- flg_clear asserted in the DONE cycle -> both bases 0 afterwards. Separately, rst_n pulsed mid-RUN -> out_valid=0 immediately and flg_ready=1.
